// File: rtl/shift_engine_n_if.sv
// Bus bundle for shift_engine_n: parallel load, start/busy/done handshake, serial chain and result.
// master = command issuer (datapath/testbench), slave = the shift engine.
interface shift_engine_n_if #(
    parameter int WIDTH = 32
);
    localparam int AW = $clog2(WIDTH) + 1;

    logic             load;
    logic [WIDTH-1:0] pdata;
    logic             start;
    logic [2:0]       mode;
    logic [AW-1:0]    amount;
    logic             abort;
    logic             SR;
    logic             SL;
    logic [WIDTH-1:0] Q;
    logic             SO;
    logic             busy;
    logic             done;

    modport master (
        output load, pdata, start, mode, amount, abort, SR, SL,
        input  Q, SO, busy, done
    );

    modport slave (
        input  load, pdata, start, mode, amount, abort, SR, SL,
        output Q, SO, busy, done
    );
endinterface

// File: rtl/shift_engine_n.sv
// WIDTH-bit shift register with parallel load and a one-bit-per-clock shift sequencer.
// Define SHIFT_ENGINE_ROTATE_EN to make ROR/ROL legal; otherwise those codes are reserved.
module shift_engine_n #(
    parameter  int WIDTH = 32,
    localparam int AW    = $clog2(WIDTH) + 1
) (
    input logic             clk,
    input logic             clear,
    shift_engine_n_if.slave bus
);
    typedef enum logic [2:0] {
        M_LSR = 3'b000,
        M_LSL = 3'b001,
        M_ASR = 3'b010,
        M_ROR = 3'b011,
        M_ROL = 3'b100
    } mode_e;

    typedef enum logic {S_IDLE, S_RUN} state_e;

    state_e           r_state, w_state_nx;
    mode_e            r_mode,  w_mode_nx;
    logic [AW-1:0]    r_cnt,   w_cnt_nx;
    logic [WIDTH-1:0] r_q,     w_q_nx;
    logic             r_so,    w_so_nx;
    logic             r_done,  w_done_nx;

    function automatic logic mode_legal(input logic [2:0] m);
        logic ok;
        case (m)
            3'b000, 3'b001, 3'b010: ok = 1'b1;
`ifdef SHIFT_ENGINE_ROTATE_EN
            3'b011, 3'b100:         ok = 1'b1;
`endif
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_state <= S_IDLE;
            r_mode  <= M_LSR;
            r_cnt   <= '0;
            r_q     <= '0;
            r_so    <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_mode  <= w_mode_nx;
            r_cnt   <= w_cnt_nx;
            r_q     <= w_q_nx;
            r_so    <= w_so_nx;
            r_done  <= w_done_nx;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nx = r_state;
        w_mode_nx  = r_mode;
        w_cnt_nx   = r_cnt;
        w_q_nx     = r_q;
        w_so_nx    = r_so;
        w_done_nx  = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (bus.load) begin
                    w_q_nx = bus.pdata;
                end else if (bus.start) begin
                    if (bus.amount != '0 && mode_legal(bus.mode)) begin
                        w_mode_nx  = mode_e'(bus.mode);
                        w_cnt_nx   = bus.amount;
                        w_state_nx = S_RUN;
                    end else begin
                        w_done_nx = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (bus.abort) begin
                    // Partial result stays in Q; an aborted sequence never signals done.
                    w_cnt_nx   = '0;
                    w_state_nx = S_IDLE;
                end else begin
                    case (r_mode)
                        M_LSR: begin
                            w_q_nx  = {bus.SR, r_q[WIDTH-1:1]};
                            w_so_nx = r_q[0];
                        end
                        M_LSL: begin
                            w_q_nx  = {r_q[WIDTH-2:0], bus.SL};
                            w_so_nx = r_q[WIDTH-1];
                        end
                        M_ASR: begin
                            w_q_nx  = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
                            w_so_nx = r_q[0];
                        end
`ifdef SHIFT_ENGINE_ROTATE_EN
                        M_ROR: begin
                            w_q_nx  = {r_q[0], r_q[WIDTH-1:1]};
                            w_so_nx = r_q[0];
                        end
                        M_ROL: begin
                            w_q_nx  = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                            w_so_nx = r_q[WIDTH-1];
                        end
`endif
                        default: ;
                    endcase
                    w_cnt_nx = r_cnt - AW'(1);
                    if (r_cnt == AW'(1)) begin
                        w_state_nx = S_IDLE;
                        w_done_nx  = 1'b1;
                    end
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    assign bus.Q    = r_q;
    assign bus.SO   = r_so;
    assign bus.busy = (r_state == S_RUN);
    assign bus.done = r_done;
endmodule

// File: tb/tb_shift_engine_n.sv
// Directed bench for shift_engine_n (WIDTH=32): one-cycle vector table plus multi-cycle sequences.
// Rotate expectations follow SHIFT_ENGINE_ROTATE_EN, matching the RTL build.
module tb_shift_engine_n;
    localparam int W  = 32;
    localparam int AW = $clog2(W) + 1;

    logic clk = 1'b0;
    logic clear;
    int   tests = 0;
    int   fails = 0;

    shift_engine_n_if #(.WIDTH(W)) ifc ();

    shift_engine_n #(.WIDTH(W)) dut (
        .clk  (clk),
        .clear(clear),
        .bus  (ifc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          load;
        logic [W-1:0]  pdata;
        logic          start;
        logic [2:0]    mode;
        logic [AW-1:0] amount;
        logic          abort;
        logic          sr;
        logic          sl;
        logic [W-1:0]  exp_q;
        logic          exp_busy;
        logic          exp_done;
        logic          exp_so;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ifc.load   = 1'b0;
        ifc.pdata  = '0;
        ifc.start  = 1'b0;
        ifc.mode   = 3'b000;
        ifc.amount = '0;
        ifc.abort  = 1'b0;
        ifc.SR     = 1'b0;
        ifc.SL     = 1'b0;
    endtask

    task automatic do_load(input logic [W-1:0] d);
        ifc.load  = 1'b1;
        ifc.pdata = d;
        tick();
        ifc.load  = 1'b0;
    endtask

    task automatic do_start(input logic [2:0] m, input logic [AW-1:0] a);
        ifc.start  = 1'b1;
        ifc.mode   = m;
        ifc.amount = a;
        tick();
        ifc.start  = 1'b0;
    endtask

    // Counts edges until busy drops, bounded so a stuck DUT still reaches the summary.
    task automatic wait_idle(output int n);
        n = 0;
        while (ifc.busy === 1'b1 && n < 200) begin
            tick();
            n++;
        end
    endtask

    function automatic vec_t mk(input logic ld, input logic [W-1:0] pd, input logic st,
                                input logic [2:0] m, input logic [AW-1:0] a, input logic ab,
                                input logic sr, input logic sl, input logic [W-1:0] q,
                                input logic b, input logic d, input logic so);
        vec_t v;
        v.load = ld; v.pdata = pd; v.start = st; v.mode = m; v.amount = a; v.abort = ab;
        v.sr = sr; v.sl = sl; v.exp_q = q; v.exp_busy = b; v.exp_done = d; v.exp_so = so;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;

        vecs[0]  = mk(1, 32'h12345678, 0, 3'b000, 6'd0, 0, 0, 0, 32'h12345678, 0, 0, 0);
        vecs[1]  = mk(0, 32'h0,        1, 3'b000, 6'd0, 0, 0, 0, 32'h12345678, 0, 1, 0);
        vecs[2]  = mk(0, 32'h0,        0, 3'b000, 6'd0, 0, 0, 0, 32'h12345678, 0, 0, 0);
        vecs[3]  = mk(0, 32'h0,        1, 3'b101, 6'd3, 0, 0, 0, 32'h12345678, 0, 1, 0);
        vecs[4]  = mk(0, 32'h0,        0, 3'b000, 6'd0, 0, 0, 0, 32'h12345678, 0, 0, 0);
        vecs[5]  = mk(0, 32'h0,        1, 3'b001, 6'd1, 0, 0, 1, 32'h12345678, 1, 0, 0);
        vecs[6]  = mk(0, 32'h0,        0, 3'b000, 6'd0, 0, 0, 1, 32'h2468ACF1, 0, 1, 0);
        vecs[7]  = mk(0, 32'h0,        1, 3'b000, 6'd2, 0, 0, 0, 32'h2468ACF1, 1, 0, 0);
        vecs[8]  = mk(0, 32'h0,        0, 3'b000, 6'd0, 0, 1, 0, 32'h92345678, 1, 0, 1);
        vecs[9]  = mk(0, 32'h0,        0, 3'b000, 6'd0, 0, 0, 0, 32'h491A2B3C, 0, 1, 0);
        vecs[10] = mk(0, 32'h0,        1, 3'b010, 6'd2, 0, 0, 0, 32'h491A2B3C, 1, 0, 0);
        vecs[11] = mk(1, 32'h0,        1, 3'b001, 6'd5, 0, 0, 0, 32'h248D159E, 1, 0, 0);
        vecs[12] = mk(0, 32'h0,        0, 3'b000, 6'd0, 1, 0, 0, 32'h248D159E, 0, 0, 0);
        vecs[13] = mk(0, 32'h0,        0, 3'b000, 6'd0, 1, 0, 0, 32'h248D159E, 0, 0, 0);
        vecs[14] = mk(1, 32'h80000001, 0, 3'b000, 6'd0, 0, 0, 0, 32'h80000001, 0, 0, 0);
        vecs[15] = mk(0, 32'h0,        1, 3'b010, 6'd1, 0, 0, 0, 32'h80000001, 1, 0, 0);
        vecs[16] = mk(0, 32'h0,        0, 3'b000, 6'd0, 0, 0, 0, 32'hC0000000, 0, 1, 1);
        vecs[17] = mk(0, 32'h0,        0, 3'b000, 6'd0, 0, 0, 0, 32'hC0000000, 0, 0, 1);

        // Reset dominates a pending load.
        idle_inputs();
        clear     = 1'b0;
        ifc.load  = 1'b1;
        ifc.pdata = 32'hFFFFFFFF;
        tick();
        tick();
        check("rst_q",    ifc.Q,    32'h0);
        check("rst_busy", ifc.busy, 1'b0);
        check("rst_done", ifc.done, 1'b0);
        check("rst_so",   ifc.SO,   1'b0);
        clear = 1'b1;
        tick();
        ifc.load = 1'b0;
        check("load_after_rst", ifc.Q, 32'hFFFFFFFF);

        // Table vectors start from a fresh reset.
        clear = 1'b0;
        #2;
        clear = 1'b1;
        for (int i = 0; i < 18; i++) begin
            ifc.load   = vecs[i].load;
            ifc.pdata  = vecs[i].pdata;
            ifc.start  = vecs[i].start;
            ifc.mode   = vecs[i].mode;
            ifc.amount = vecs[i].amount;
            ifc.abort  = vecs[i].abort;
            ifc.SR     = vecs[i].sr;
            ifc.SL     = vecs[i].sl;
            tick();
            check($sformatf("vec%0d_q", i),    ifc.Q,    vecs[i].exp_q);
            check($sformatf("vec%0d_busy", i), ifc.busy, vecs[i].exp_busy);
            check($sformatf("vec%0d_done", i), ifc.done, vecs[i].exp_done);
            check($sformatf("vec%0d_so", i),   ifc.SO,   vecs[i].exp_so);
        end
        idle_inputs();

        // LSR 32 with SR=1 streamed in.
        do_load(32'h80000000);
        ifc.SR = 1'b1;
        do_start(3'b000, 6'd32);
        wait_idle(n);
        ifc.SR = 1'b0;
        check("lsr32_cycles", n,        32);
        check("lsr32_q",      ifc.Q,    32'hFFFFFFFF);
        check("lsr32_so",     ifc.SO,   1'b1);
        check("lsr32_done",   ifc.done, 1'b1);
        tick();
        check("lsr32_done_clr", ifc.done, 1'b0);

        // ASR sign fill, then LSL with zero fill.
        do_load(32'h80000000);
        do_start(3'b010, 6'd31);
        wait_idle(n);
        check("asr31_cycles", n,     31);
        check("asr31_q",      ifc.Q, 32'hFFFFFFFF);
        ifc.SL = 1'b0;
        do_start(3'b001, 6'd4);
        wait_idle(n);
        check("lsl4_q", ifc.Q, 32'hFFFFFFF0);

        // Amount beyond WIDTH saturates a logical shift.
        do_load(32'hFFFFFFFF);
        do_start(3'b001, 6'd40);
        wait_idle(n);
        check("lsl40_cycles", n,      40);
        check("lsl40_q",      ifc.Q,  32'h0);
        check("lsl40_so",     ifc.SO, 1'b0);
        tick();

        // Rotate left by one.
        do_load(32'hAAAAAAAA);
        do_start(3'b100, 6'd1);
`ifdef SHIFT_ENGINE_ROTATE_EN
        check("rol_busy", ifc.busy, 1'b1);
        wait_idle(n);
        check("rol_q",    ifc.Q,    32'h55555555);
        check("rol_so",   ifc.SO,   1'b1);
        check("rol_done", ifc.done, 1'b1);
        tick();
        do_load(32'h00000001);
        do_start(3'b011, 6'd33);
        wait_idle(n);
        check("ror33_cycles", n,     33);
        check("ror33_q",      ifc.Q, 32'h80000000);
`else
        check("rol_off_busy", ifc.busy, 1'b0);
        check("rol_off_done", ifc.done, 1'b1);
        check("rol_off_q",    ifc.Q,    32'hAAAAAAAA);
        do_start(3'b011, 6'd1);
        check("ror_off_busy", ifc.busy, 1'b0);
        check("ror_off_done", ifc.done, 1'b1);
        check("ror_off_q",    ifc.Q,    32'hAAAAAAAA);
`endif
        tick();

        // Abort after two shifts keeps the partial result and gives no done.
        do_load(32'h000000F0);
        do_start(3'b000, 6'd8);
        tick();
        tick();
        check("abort_partial", ifc.Q, 32'h0000003C);
        ifc.abort = 1'b1;
        tick();
        ifc.abort = 1'b0;
        check("abort_q",    ifc.Q,    32'h0000003C);
        check("abort_busy", ifc.busy, 1'b0);
        check("abort_done", ifc.done, 1'b0);
        tick();
        check("abort_done2", ifc.done, 1'b0);

        // Asynchronous reset in the middle of a 10-shift sequence.
        do_load(32'h0000FFFF);
        do_start(3'b001, 6'd10);
        tick();
        tick();
        tick();
        clear = 1'b0;
        #1;
        check("midrst_q",    ifc.Q,    32'h0);
        check("midrst_busy", ifc.busy, 1'b0);
        check("midrst_done", ifc.done, 1'b0);
        tick();
        clear = 1'b1;
        tick();
        check("midrst_after_busy", ifc.busy, 1'b0);
        check("midrst_after_done", ifc.done, 1'b0);

        // Start in the done cycle is accepted.
        do_load(32'h00000001);
        do_start(3'b001, 6'd1);
        tick();
        check("b2b_first_done", ifc.done, 1'b1);
        check("b2b_first_q",    ifc.Q,    32'h00000002);
        do_start(3'b001, 6'd1);
        check("b2b_busy", ifc.busy, 1'b1);
        tick();
        check("b2b_q",    ifc.Q,    32'h00000004);
        check("b2b_done", ifc.done, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
